// File: rtl/stim_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : stim_sweep_gen
//  Description : Exhaustive stimulus sweep generator with a 16-bit MISR
//                response compactor for small combinational DUTs. Drives
//                every 2^WIDTH input vector, holds each for HOLD cycles and
//                folds the DUT response into the signature on the last hold
//                cycle of every vector.
//  Option      : define STIM_SWEEP_GRAY_EN to add the gray_mode input
//                (latched at start) selecting Gray-code vector order.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_sweep_gen #(
  parameter int WIDTH  = 3,
  parameter int HOLD   = 25,
  parameter int RESP_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
`ifdef STIM_SWEEP_GRAY_EN
  input  logic              gray_mode,
`endif
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  stim,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sig,
  output logic [WIDTH:0]    vec_count
);

  localparam int                 DWELL_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD - 1);
  localparam logic [WIDTH-1:0]   IDX_LAST   = '1;
  localparam logic [15:0]        MISR_POLY  = 16'h1021;
  localparam logic [15:0]        MISR_SEED  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic [15:0]        sig_q, sig_d;
  logic [WIDTH:0]     vec_count_q, vec_count_d;
  logic [15:0]        resp_ext;
  logic [15:0]        misr_next;
  logic [WIDTH-1:0]   idx_inc;
  logic               gray_sel;
  logic               gray_start;

  // Vector index to presented stimulus: binary, or reflected Gray code.
  function automatic logic [WIDTH-1:0] vec_order(input logic [WIDTH-1:0] i,
                                                 input logic             g);
    return g ? (i ^ (i >> 1)) : i;
  endfunction

`ifdef STIM_SWEEP_GRAY_EN
  logic gray_q, gray_d;

  // Gray-order selection is captured when a sweep launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gray_q <= 1'b0;
    else        gray_q <= gray_d;
  end

  assign gray_start = gray_mode;
  assign gray_sel   = gray_q;
  assign gray_d     = (state_q == S_IDLE && start) ? gray_mode : gray_q;
`else
  assign gray_start = 1'b0;
  assign gray_sel   = 1'b0;
`endif

  // Zero-extend the response and compute the next MISR state.
  always_comb begin
    resp_ext               = '0;
    resp_ext[RESP_W-1:0]   = resp;
    misr_next              = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? MISR_POLY : 16'h0000) ^ resp_ext;
    idx_inc                = idx_q + WIDTH'(1);
  end

  // Next-state and datapath update for the sweep controller.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    stim_d      = stim_q;
    sig_d       = sig_q;
    vec_count_d = vec_count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          idx_d       = '0;
          dwell_d     = '0;
          stim_d      = vec_order('0, gray_start);
          sig_d       = MISR_SEED;
          vec_count_d = '0;
        end
      end
      S_RUN: begin
        // An abort wins over a coincident sample, which is then dropped.
        if (stop) begin
          state_d = S_IDLE;
        end else if (dwell_q == DWELL_LAST) begin
          sig_d       = misr_next;
          vec_count_d = vec_count_q + (WIDTH+1)'(1);
          dwell_d     = '0;
          if (idx_q == IDX_LAST) begin
            // Leave the last vector on stim rather than wrapping the index.
            state_d = S_FINISH;
          end else begin
            idx_d  = idx_inc;
            stim_d = vec_order(idx_inc, gray_sel);
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dwell_q     <= '0;
      stim_q      <= '0;
      sig_q       <= MISR_SEED;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      stim_q      <= stim_d;
      sig_q       <= sig_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign stim       = stim_q;
  assign stim_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_FINISH);
  assign sig        = sig_q;
  assign vec_count  = vec_count_q;

endmodule
`default_nettype wire

// File: tb/tb_stim_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stim_sweep_gen
//  Description : Directed self-checking bench for stim_sweep_gen (default
//                parameters plus a WIDTH=4/HOLD=1 instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_sweep_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        resp_sel;
  logic [0:0]  resp;
  logic [2:0]  stim;
  logic        stim_valid;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic [3:0]  vec_count;
`ifdef STIM_SWEEP_GRAY_EN
  logic        gray_mode;
`endif

  logic        start4;
  logic        stop4;
  logic [0:0]  resp4;
  logic [3:0]  stim4;
  logic        stim_valid4;
  logic        busy4;
  logic        done4;
  logic [15:0] sig4;
  logic [4:0]  vec_count4;

  int n_checks;
  int n_fail;

  // Parity DUT or constant 0 in front of the default instance.
  assign resp  = resp_sel ? (^stim) : 1'b0;
  assign resp4 = 1'b0;

  stim_sweep_gen u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
`ifdef STIM_SWEEP_GRAY_EN
    .gray_mode  (gray_mode),
`endif
    .resp       (resp),
    .stim       (stim),
    .stim_valid (stim_valid),
    .busy       (busy),
    .done       (done),
    .sig        (sig),
    .vec_count  (vec_count)
  );

  stim_sweep_gen #(.WIDTH(4), .HOLD(1), .RESP_W(1)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .stop       (stop4),
`ifdef STIM_SWEEP_GRAY_EN
    .gray_mode  (1'b0),
`endif
    .resp       (resp4),
    .stim       (stim4),
    .stim_valid (stim_valid4),
    .busy       (busy4),
    .done       (done4),
    .sig        (sig4),
    .vec_count  (vec_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch a sweep on the default instance; returns at the first negedge after
  // the launching edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({stim, stim_valid, busy, done} !== 6'b000_000) begin
      n_fail++;
      $display("FAIL reset_ctl: got stim=%0d v=%b b=%b d=%b want 0/0/0/0", stim, stim_valid, busy, done);
    end
    n_checks++;
    if (sig !== 16'hFFFF || vec_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_sig: got sig=%h cnt=%0d want ffff/0", sig, vec_count);
    end
    n_checks++;
    if (stim4 !== 4'd0 || busy4 !== 1'b0 || sig4 !== 16'hFFFF || vec_count4 !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_w4: got stim=%0d b=%b sig=%h cnt=%0d want 0/0/ffff/0", stim4, busy4, sig4, vec_count4);
    end
  endtask

  task automatic test_sweep_zero();
    logic [5:0] obs;
    logic [5:0] exp;
    resp_sel = 1'b0;
    pulse_start();
    for (int j = 1; j <= 202; j++) begin
      if (j > 1) @(negedge clk);
      obs = {stim, stim_valid, busy, done};
      if (j <= 200)      exp = {3'((j - 1) / 25), 3'b110};
      else if (j == 201) exp = {3'd7, 3'b001};
      else               exp = {3'd7, 3'b000};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL sweep_zero_cycle%0d: got {stim,v,b,d}=%b want %b", j, obs, exp);
      end
    end
    n_checks++;
    if (vec_count !== 4'd8 || sig !== 16'hE1F0) begin
      n_fail++;
      $display("FAIL sweep_zero_sig: got cnt=%0d sig=%h want 8/e1f0", vec_count, sig);
    end
  endtask

  task automatic test_parity();
    bit seen;
    seen     = 1'b0;
    resp_sel = 1'b1;
    pulse_start();
    for (int j = 1; j <= 250 && !seen; j++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL parity_done: got no done within 250 cycles want done");
    end
    n_checks++;
    if (vec_count !== 4'd8 || sig !== 16'hE199) begin
      n_fail++;
      $display("FAIL parity_sig: got cnt=%0d sig=%h want 8/e199", vec_count, sig);
    end
    resp_sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stop();
    bit bad_done;
    bad_done = 1'b0;
    resp_sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 30) begin
        n_checks++;
        if (stim !== 3'd1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stop_no_restart: got stim=%0d busy=%b want 1/1", stim, busy);
        end
      end
    end
    stop  = 1'b1;
    start = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if ({stim, stim_valid, busy, done} !== 6'b010_000 || vec_count !== 4'd2 || sig !== 16'hCF9F) begin
      n_fail++;
      $display("FAIL stop_abort: got stim=%0d v=%b b=%b d=%b cnt=%0d sig=%h want 2/0/0/0/2/cf9f",
               stim, stim_valid, busy, done, vec_count, sig);
    end
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (done || busy) bad_done = 1'b1;
    end
    n_checks++;
    if (bad_done || vec_count !== 4'd2 || sig !== 16'hCF9F) begin
      n_fail++;
      $display("FAIL stop_frozen: got activity=%b cnt=%0d sig=%h want 0/2/cf9f", bad_done, vec_count, sig);
    end
  endtask

  task automatic test_stop_on_sample();
    pulse_start();
    for (int j = 2; j <= 50; j++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || vec_count !== 4'd1 || sig !== 16'hEFDF || stim !== 3'd1) begin
      n_fail++;
      $display("FAIL stop_on_sample: got busy=%b cnt=%0d sig=%h stim=%0d want 0/1/efdf/1",
               busy, vec_count, sig, stim);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int j = 2; j <= 100; j++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stim, stim_valid, busy, done} !== 6'b000_000 || sig !== 16'hFFFF || vec_count !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset: got stim=%0d v=%b b=%b d=%b sig=%h cnt=%0d want all reset",
               stim, stim_valid, busy, done, sig, vec_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    n_checks++;
    if (stim !== 3'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_first: got stim=%0d busy=%b want 0/1", stim, busy);
    end
    for (int j = 2; j <= 26; j++) @(negedge clk);
    n_checks++;
    if (stim !== 3'd1 || vec_count !== 4'd1) begin
      n_fail++;
      $display("FAIL restart_second: got stim=%0d cnt=%0d want 1/1", stim, vec_count);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_width4_hold1();
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      if (j > 1) @(negedge clk);
      n_checks++;
      if (j <= 16) begin
        if (stim4 !== 4'(j - 1) || stim_valid4 !== 1'b1 || done4 !== 1'b0) begin
          n_fail++;
          $display("FAIL w4_cycle%0d: got stim=%0d v=%b d=%b want %0d/1/0", j, stim4, stim_valid4, done4, j - 1);
        end
      end else begin
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
          n_fail++;
          $display("FAIL w4_done: got done=%b busy=%b want 1/0", done4, busy4);
        end
      end
    end
    n_checks++;
    if (vec_count4 !== 5'd16 || sig4 !== 16'h1D0F) begin
      n_fail++;
      $display("FAIL w4_sig: got cnt=%0d sig=%h want 16/1d0f", vec_count4, sig4);
    end
  endtask

`ifdef STIM_SWEEP_GRAY_EN
  task automatic test_gray();
    logic [2:0] gray_tab [8];
    logic [5:0] obs;
    logic [5:0] exp;
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    resp_sel = 1'b0;
    @(negedge clk);
    start     = 1'b1;
    gray_mode = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    gray_mode = 1'b0;
    for (int j = 1; j <= 201; j++) begin
      if (j > 1) @(negedge clk);
      obs = {stim, stim_valid, busy, done};
      if (j <= 200) exp = {gray_tab[(j - 1) / 25], 3'b110};
      else          exp = {3'd4, 3'b001};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL gray_cycle%0d: got {stim,v,b,d}=%b want %b", j, obs, exp);
      end
    end
    n_checks++;
    if (vec_count !== 4'd8 || sig !== 16'hE1F0) begin
      n_fail++;
      $display("FAIL gray_sig: got cnt=%0d sig=%h want 8/e1f0", vec_count, sig);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    start4   = 1'b0;
    stop4    = 1'b0;
    resp_sel = 1'b0;
`ifdef STIM_SWEEP_GRAY_EN
    gray_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_sweep_zero();
    test_parity();
    test_stop();
    test_stop_on_sample();
    test_async_reset();
    test_width4_hold1();
`ifdef STIM_SWEEP_GRAY_EN
    test_gray();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
